// File: rtl/sva_seq_checker.sv
`timescale 1ns/1ps
// Multi-thread sequence checker: samples gclk as data in the sys_clk domain and tracks
// up to THREAD_NUM overlapping SEQ_LEN-step attempts. Define SVA_SEQ_CNT_EN for succ/fail counters.
module sva_seq_checker #(
    parameter int SIG_W       = 4,
    parameter int SEQ_LEN     = 3,
    parameter int THREAD_NUM  = 4,
    parameter int TIMER_WIDTH = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     gclk,
    input  logic [SIG_W-1:0]         sig,
    input  logic [SEQ_LEN*SIG_W-1:0] step_val,
    input  logic [SEQ_LEN*SIG_W-1:0] step_mask,
    input  logic                     clr,
    output logic                     busy,
    output logic                     succ,
    output logic                     fail,
    output logic [TIMER_WIDTH-1:0]   fail_period,
    output logic                     overflow,
    output logic                     overrun
`ifdef SVA_SEQ_CNT_EN
    ,
    output logic [15:0]              succ_cnt,
    output logic [15:0]              fail_cnt
`endif
);
    localparam int STEP_W = $clog2(SEQ_LEN) + 1;
    localparam int IDX_W  = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_SPAWN} state_t;

    typedef struct packed {
        logic                   active;
        logic [STEP_W-1:0]      step;
        logic [TIMER_WIDTH-1:0] start_period;
    } slot_t;

    logic                   gclk_d0, gclk_d1, gclk_edge;
    logic                   pending_q;
    logic [SIG_W-1:0]       sig_hold_q, sig_smp_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    state_t                 state_q, state_n;
    logic [IDX_W-1:0]       idx_q, idx_n, free_idx;
    logic                   free_found, start_round;
    slot_t                  slot_q [THREAD_NUM];
    slot_t                  slot_n [THREAD_NUM];
    logic                   succ_n, fail_n, overflow_n;
    logic [TIMER_WIDTH-1:0] fail_period_n;

    assign gclk_edge   = gclk_d0 & ~gclk_d1;
    assign start_round = (state_q == S_IDLE) && (gclk_edge || pending_q);
    assign busy        = (state_q != S_IDLE);

    function automatic logic step_match(input logic [STEP_W-1:0] k);
        logic [SIG_W-1:0] v;
        logic [SIG_W-1:0] m;
        v = step_val[int'(k)*SIG_W +: SIG_W];
        m = step_mask[int'(k)*SIG_W +: SIG_W];
        return ((sig_smp_q ^ v) & m) == '0;
    endfunction

    // Sample front end: the hold register keeps an edge's sample while a round is running.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gclk_d0    <= 1'b0;
            gclk_d1    <= 1'b0;
            pending_q  <= 1'b0;
            sig_hold_q <= '0;
            sig_smp_q  <= '0;
            timer_q    <= '0;
            overrun    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values regardless of statement order.
            gclk_d0 <= gclk;
            gclk_d1 <= gclk_d0;
            overrun <= 1'b0;
            if (gclk_edge) timer_q <= timer_q + TIMER_WIDTH'(1);
            if (clr) begin
                pending_q <= 1'b0;
            end else if (state_q == S_IDLE) begin
                if (pending_q) begin
                    sig_smp_q <= sig_hold_q;
                    if (gclk_edge) sig_hold_q <= sig;
                    else           pending_q  <= 1'b0;
                end else if (gclk_edge) begin
                    sig_smp_q <= sig;
                end
            end else if (gclk_edge) begin
                if (pending_q) begin
                    overrun <= 1'b1;
                end else begin
                    pending_q  <= 1'b1;
                    sig_hold_q <= sig;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            succ        <= 1'b0;
            fail        <= 1'b0;
            overflow    <= 1'b0;
            fail_period <= '0;
            // NOTE: the slot array is reset explicitly because stale 'active' bits would fire spurious results.
            for (int i = 0; i < THREAD_NUM; i++) slot_q[i] <= '0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            succ        <= succ_n;
            fail        <= fail_n;
            overflow    <= overflow_n;
            fail_period <= fail_period_n;
            slot_q      <= slot_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n       = state_q;
        idx_n         = idx_q;
        slot_n        = slot_q;
        succ_n        = 1'b0;
        fail_n        = 1'b0;
        overflow_n    = 1'b0;
        fail_period_n = fail_period;
        free_found    = 1'b0;
        free_idx      = '0;
        case (state_q)
            S_IDLE: begin
                if (start_round) begin
                    state_n = S_EVAL;
                    idx_n   = '0;
                end
            end
            S_EVAL: begin
                if (slot_q[idx_q].active) begin
                    if (step_match(slot_q[idx_q].step)) begin
                        if (slot_q[idx_q].step == STEP_W'(SEQ_LEN - 1)) begin
                            succ_n                = 1'b1;
                            slot_n[idx_q].active  = 1'b0;
                        end else begin
                            slot_n[idx_q].step = slot_q[idx_q].step + STEP_W'(1);
                        end
                    end else begin
                        fail_n               = 1'b1;
                        fail_period_n        = slot_q[idx_q].start_period;
                        slot_n[idx_q].active = 1'b0;
                    end
                end
                if (idx_q == IDX_W'(THREAD_NUM - 1)) state_n = S_SPAWN;
                else                                 idx_n   = idx_q + IDX_W'(1);
            end
            S_SPAWN: begin
                state_n = S_IDLE;
                if (step_match('0)) begin
                    if (SEQ_LEN == 1) begin
                        succ_n = 1'b1;
                    end else begin
                        // Descending scan so the lowest free slot is the one that sticks.
                        for (int i = THREAD_NUM - 1; i >= 0; i--) begin
                            if (!slot_q[i].active) begin
                                free_found = 1'b1;
                                free_idx   = IDX_W'(i);
                            end
                        end
                        if (free_found) slot_n[free_idx] = '{active: 1'b1, step: STEP_W'(1), start_period: timer_q};
                        else            overflow_n       = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (clr) begin
            state_n       = S_IDLE;
            idx_n         = '0;
            succ_n        = 1'b0;
            fail_n        = 1'b0;
            overflow_n    = 1'b0;
            fail_period_n = fail_period;
            for (int i = 0; i < THREAD_NUM; i++) slot_n[i].active = 1'b0;
        end
    end

`ifdef SVA_SEQ_CNT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr) begin
            succ_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (succ && succ_cnt != 16'hFFFF) succ_cnt <= succ_cnt + 16'd1;
            if (fail && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sva_seq_checker.sv
`timescale 1ns/1ps
// Directed bench for sva_seq_checker: instance a (SEQ_LEN=3, 4 slots) for the main flows,
// instance b (SEQ_LEN=5, 3 slots) for overflow and clr with three live slots.
module tb_sva_seq_checker;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       gclk = 1'b0;
    logic [1:0] sig = 2'b00;
    logic       clr = 1'b0;

    logic [5:0] a_step_val  = 6'b11_10_01;
    logic [5:0] a_step_mask = 6'b11_11_11;
    logic       a_busy, a_succ, a_fail, a_ovf, a_ovr;
    logic [7:0] a_fail_period;

    logic [9:0] b_step_val  = 10'b00_00_00_00_01;
    logic [9:0] b_step_mask = 10'b00_00_00_00_11;
    logic       b_busy, b_succ, b_fail, b_ovf, b_ovr;
    logic [7:0] b_fail_period;

`ifdef SVA_SEQ_CNT_EN
    logic [15:0] a_succ_cnt, a_fail_cnt, b_succ_cnt, b_fail_cnt;
`endif

    sva_seq_checker #(.SIG_W(2), .SEQ_LEN(3), .THREAD_NUM(4), .TIMER_WIDTH(8)) u_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gclk(gclk), .sig(sig),
        .step_val(a_step_val), .step_mask(a_step_mask), .clr(clr),
        .busy(a_busy), .succ(a_succ), .fail(a_fail), .fail_period(a_fail_period),
        .overflow(a_ovf), .overrun(a_ovr)
`ifdef SVA_SEQ_CNT_EN
        , .succ_cnt(a_succ_cnt), .fail_cnt(a_fail_cnt)
`endif
    );

    sva_seq_checker #(.SIG_W(2), .SEQ_LEN(5), .THREAD_NUM(3), .TIMER_WIDTH(8)) u_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .gclk(gclk), .sig(sig),
        .step_val(b_step_val), .step_mask(b_step_mask), .clr(clr),
        .busy(b_busy), .succ(b_succ), .fail(b_fail), .fail_period(b_fail_period),
        .overflow(b_ovf), .overrun(b_ovr)
`ifdef SVA_SEQ_CNT_EN
        , .succ_cnt(b_succ_cnt), .fail_cnt(b_fail_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int tmr   = 0;

    // Pulse counters sampled on the falling edge.
    int   a_succ_n = 0, a_fail_n = 0, a_ovf_n = 0, a_ovr_n = 0, a_busy_rise = 0;
    int   b_succ_n = 0, b_fail_n = 0, b_ovf_n = 0;
    int   idle_run = 0, idle_max = 0;
    logic a_busy_d = 1'b0;
    logic ov_win = 1'b0, ov_win_d = 1'b0;

    always @(negedge sys_clk) begin
        a_busy_d <= a_busy;
        ov_win_d <= ov_win;
        if (a_succ === 1'b1) a_succ_n <= a_succ_n + 1;
        if (a_fail === 1'b1) a_fail_n <= a_fail_n + 1;
        if (a_ovf  === 1'b1) a_ovf_n  <= a_ovf_n + 1;
        if (a_ovr  === 1'b1) a_ovr_n  <= a_ovr_n + 1;
        if (a_busy === 1'b1 && a_busy_d !== 1'b1) a_busy_rise <= a_busy_rise + 1;
        if (b_succ === 1'b1) b_succ_n <= b_succ_n + 1;
        if (b_fail === 1'b1) b_fail_n <= b_fail_n + 1;
        if (b_ovf  === 1'b1) b_ovf_n  <= b_ovf_n + 1;
        if (ov_win) begin
            if (!ov_win_d || a_busy === 1'b1) begin
                idle_run <= 0;
            end else begin
                idle_run <= idle_run + 1;
                if (idle_run + 1 > idle_max) idle_max <= idle_run + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One slow gclk period (16 sys_clk): a full round of either instance completes inside it.
    task automatic gclk_pulse(input logic [1:0] v);
        @(negedge sys_clk);
        sig  = v;
        gclk = 1'b1;
        repeat (8) @(negedge sys_clk);
        gclk = 1'b0;
        repeat (8) @(negedge sys_clk);
        tmr++;
    endtask

    // gclk period of 4 sys_clk, faster than a round can absorb.
    task automatic fast_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            gclk = 1'b1;
            @(negedge sys_clk);
            @(negedge sys_clk);
            gclk = 1'b0;
            @(negedge sys_clk);
            tmr++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge sys_clk);
        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s_succ, s_fail, s_ovf, s_ovr, s_rise;
        int   exp_ovl_succ [6] = '{0, 0, 1, 2, 3, 4};
        int   exp_b_ovf [5]    = '{0, 0, 0, 1, 1};
        int   exp_b_succ [5]   = '{0, 0, 0, 0, 1};
        logic seen;

        repeat (3) @(negedge sys_clk);
        check("rst_a_busy", a_busy, 1'b0);
        check("rst_a_succ", a_succ, 1'b0);
        check("rst_a_fail", a_fail, 1'b0);
        check("rst_a_ovf", a_ovf, 1'b0);
        check("rst_a_ovr", a_ovr, 1'b0);
        check("rst_a_fail_period", a_fail_period, 8'd0);
        check("rst_b_busy", b_busy, 1'b0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single pass: 01, 10, 11 completes one attempt in round 3.
        gclk_pulse(2'b01);
        check("pass_r1_succ", a_succ_n, 0);
        gclk_pulse(2'b10);
        check("pass_r2_succ", a_succ_n, 0);
        gclk_pulse(2'b11);
        check("pass_r3_succ", a_succ_n, 1);
        check("pass_fail", a_fail_n, 0);
        check("pass_busy_idle", a_busy, 1'b0);
`ifdef SVA_SEQ_CNT_EN
        check("pass_succ_cnt", a_succ_cnt, 16'd1);
        check("pass_fail_cnt", a_fail_cnt, 16'd0);
`endif

        // Failure: 01 then 00; fail_period is the timer of the starting round (4th edge).
        gclk_pulse(2'b01);
        check("fail_r1_fail", a_fail_n, 0);
        gclk_pulse(2'b00);
        check("fail_r2_fail", a_fail_n, 1);
        check("fail_period", a_fail_period, 8'd4);
        check("fail_no_succ", a_succ_n, 1);

        // Vacuous: no antecedent for 10 edges, one busy window per edge.
        s_succ = a_succ_n; s_fail = a_fail_n; s_ovf = a_ovf_n; s_rise = a_busy_rise;
        for (int i = 0; i < 10; i++) gclk_pulse(2'b00);
        check("vac_succ", a_succ_n - s_succ, 0);
        check("vac_fail", a_fail_n - s_fail, 0);
        check("vac_ovf", a_ovf_n - s_ovf, 0);
        check("vac_busy_rounds", a_busy_rise - s_rise, 10);

        // Overlap: later steps unmasked, each attempt completes two rounds after it starts.
        a_step_mask = 6'b00_00_11;
        s_succ = a_succ_n; s_fail = a_fail_n; s_ovf = a_ovf_n;
        for (int i = 0; i < 6; i++) begin
            gclk_pulse(2'b01);
            check($sformatf("ovl_r%0d_succ", i + 1), a_succ_n - s_succ, exp_ovl_succ[i]);
        end
        check("ovl_fail", a_fail_n - s_fail, 0);
        check("ovl_ovf", a_ovf_n - s_ovf, 0);

        // clr while idle with two live slots: nothing may resolve afterwards.
        a_step_mask = 6'b11_11_11;
        pulse_clr();
        check("clr_a_busy", a_busy, 1'b0);
        s_succ = a_succ_n; s_fail = a_fail_n;
        gclk_pulse(2'b00);
        check("clr_a_succ", a_succ_n - s_succ, 0);
        check("clr_a_fail", a_fail_n - s_fail, 0);

        // Overflow on b: three slots, attempts live four rounds, so round 4 finds no free slot.
        pulse_clr();
        s_succ = b_succ_n; s_ovf = b_ovf_n;
        for (int i = 0; i < 5; i++) begin
            gclk_pulse(2'b01);
            check($sformatf("b_ovf_r%0d", i + 1), b_ovf_n - s_ovf, exp_b_ovf[i]);
            check($sformatf("b_succ_r%0d", i + 1), b_succ_n - s_succ, exp_b_succ[i]);
        end

        // clr during EVAL idx 1 of round 4 with three live slots on b.
        pulse_clr();
        for (int i = 0; i < 3; i++) gclk_pulse(2'b01);
        s_succ = b_succ_n; s_fail = b_fail_n;
        @(negedge sys_clk);
        sig  = 2'b00;
        gclk = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sys_clk);
            if (b_busy === 1'b1) seen = 1'b1;
        end
        check("clr_sync_busy", seen, 1'b1);
        @(negedge sys_clk);
        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        check("clr_mid_busy", b_busy, 1'b0);
        repeat (6) @(negedge sys_clk);
        gclk = 1'b0;
        repeat (8) @(negedge sys_clk);
        tmr++;
        for (int i = 0; i < 4; i++) gclk_pulse(2'b00);
        check("clr_mid_succ", b_succ_n - s_succ, 0);
        check("clr_mid_fail", b_fail_n - s_fail, 0);
        for (int i = 0; i < 4; i++) gclk_pulse(2'b01);
        check("clr_new_r4_succ", b_succ_n - s_succ, 0);
        gclk_pulse(2'b01);
        check("clr_new_r5_succ", b_succ_n - s_succ, 1);

        // Overrun: no drops so far; fast gclk drops edges and keeps a nearly always busy.
        check("slow_no_overrun", a_ovr_n, 0);
        pulse_clr();
        sig = 2'b00;
        s_ovr = a_ovr_n; s_succ = a_succ_n; s_fail = a_fail_n;
        fast_edges(3);
        ov_win = 1'b1;
        fast_edges(16);
        ov_win = 1'b0;
        repeat (40) @(negedge sys_clk);
        check("overrun_seen", (a_ovr_n - s_ovr) > 0, 1'b1);
        check("overrun_busy_gap", idle_max <= 1, 1'b1);
        check("overrun_no_succ", a_succ_n - s_succ, 0);
        check("overrun_no_fail", a_fail_n - s_fail, 0);

        // Asynchronous reset in the middle of a round.
        @(negedge sys_clk);
        gclk = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sys_clk);
            if (a_busy === 1'b1) seen = 1'b1;
        end
        check("arst_sync_busy", seen, 1'b1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst_a_busy", a_busy, 1'b0);
        check("arst_b_busy", b_busy, 1'b0);
        check("arst_fail_period", a_fail_period, 8'd0);
        @(negedge sys_clk);
        gclk = 1'b0;
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
